// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access paths.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_ce,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_data,
    output logic                if_ready,
    input  logic                dm_ce,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_sel,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_ce,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_sel,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq_if,
    output logic                stallreq_mem
);

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_cfg
            $error("mem_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       owner;     // 0 = fetch, 1 = data
    logic       grant_dm;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dm;  // reset to 0 so the first tie goes to the data side

    always_comb grant_dm = dm_ce & (~if_ce | ~last_dm);

    always_ff @(posedge clk) begin
        if (rst)
            last_dm <= 1'b0;
        else if (state == IDLE && (if_ce || dm_ce))
            last_dm <= grant_dm;
    end
`else
    always_comb grant_dm = dm_ce;
`endif

    // The mem_* registers double as the request latches for the whole access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            mem_ce    <= 1'b0;
            mem_we    <= 1'b0;
            mem_sel   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_data   <= '0;
            dm_rdata  <= '0;
            if_ready  <= 1'b0;
            dm_ready  <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_ce || dm_ce) begin
                        owner  <= grant_dm;
                        cnt    <= CNT_INIT;
                        mem_ce <= 1'b1;
                        state  <= BUSY;
                        if (grant_dm) begin
                            mem_we    <= dm_we;
                            mem_sel   <= dm_sel;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_sel   <= '1;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        mem_ce <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                        if (owner) begin
                            dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end else begin
                            if_data  <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stallreq_if  = if_ce & ~(state == DONE && owner == 1'b0);
    assign stallreq_mem = dm_ce & ~(state == DONE && owner == 1'b1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: four instances with WAIT_CYCLES = 1..4 share stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_ce, dm_ce, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_sel;

    logic [31:0] if_data   [1:4];
    logic [31:0] dm_rdata  [1:4];
    logic        if_ready  [1:4];
    logic        dm_ready  [1:4];
    logic        mem_ce    [1:4];
    logic        mem_we    [1:4];
    logic [3:0]  mem_sel   [1:4];
    logic [31:0] mem_addr  [1:4];
    logic [31:0] mem_wdata [1:4];
    logic [31:0] mem_rdata [1:4];
    logic        stall_if  [1:4];
    logic        stall_mem [1:4];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 4; g++) begin : g_dut
        logic [31:0] mem [0:63];

        initial begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[4] = 32'h3C01_0101;
            mem[8] = 32'h1122_3344;
        end

        always @(posedge clk)
            if (mem_ce[g] && mem_we[g])
                for (int b = 0; b < 4; b++)
                    if (mem_sel[g][b]) mem[mem_addr[g][7:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];

        assign mem_rdata[g] = mem[mem_addr[g][7:2]];

        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(g)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .if_ce        (if_ce),
            .if_addr      (if_addr),
            .if_data      (if_data[g]),
            .if_ready     (if_ready[g]),
            .dm_ce        (dm_ce),
            .dm_we        (dm_we),
            .dm_sel       (dm_sel),
            .dm_addr      (dm_addr),
            .dm_wdata     (dm_wdata),
            .dm_rdata     (dm_rdata[g]),
            .dm_ready     (dm_ready[g]),
            .mem_ce       (mem_ce[g]),
            .mem_we       (mem_we[g]),
            .mem_sel      (mem_sel[g]),
            .mem_addr     (mem_addr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_rdata    (mem_rdata[g]),
            .stallreq_if  (stall_if[g]),
            .stallreq_mem (stall_mem[g])
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and checks happen here.
    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench in an IDLE cycle with rst low and no requests.
    task automatic do_reset();
        rst = 1'b1; if_ce = 1'b0; dm_ce = 1'b0; dm_we = 1'b0;
        nxt();
        nxt();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_ce = 1'b1; dm_ce = 1'b1; dm_we = 1'b0; dm_sel = 4'hF;
        if_addr = 32'h10; dm_addr = 32'h20; dm_wdata = 32'h0;

        // reset with both requests high
        for (int c = 0; c < 3; c++) begin
            nxt();
            for (int w = 1; w <= 4; w++) begin
                chk($sformatf("rst_mem_ce_w%0d", w), mem_ce[w], 1'b0);
                chk($sformatf("rst_rdy_w%0d", w), {if_ready[w], dm_ready[w]}, 2'b00);
            end
        end
        chk("rst_if_data", if_data[1], 32'h0);
        chk("rst_dm_rdata", dm_rdata[1], 32'h0);
        chk("rst_mem_addr", mem_addr[1], 32'h0);
        chk("rst_stall_if", stall_if[1], 1'b1);
        rst = 1'b0;
        nxt();
        chk("rel_mem_ce", mem_ce[1], 1'b1);
        chk("rel_dm_first", mem_addr[1], 32'h20);
        chk("rel_stall_mem_busy", stall_mem[1], 1'b1);
        nxt();
        chk("rel_dm_ready", dm_ready[1], 1'b1);
        chk("rel_dm_rdata", dm_rdata[1], 32'h1122_3344);
        chk("rel_stall_mem_done", stall_mem[1], 1'b0);
        chk("rel_stall_if_done", stall_if[1], 1'b1);

        // single fetch, W=1
        do_reset();
        if_ce = 1'b1; if_addr = 32'h10;
        #1;
        chk("f_c0_stall", stall_if[1], 1'b1);
        chk("f_c0_mem_ce", mem_ce[1], 1'b0);
        nxt();
        chk("f_c1_mem_ce", mem_ce[1], 1'b1);
        chk("f_c1_mem_we", mem_we[1], 1'b0);
        chk("f_c1_mem_sel", mem_sel[1], 4'hF);
        chk("f_c1_mem_addr", mem_addr[1], 32'h10);
        chk("f_c1_stall", stall_if[1], 1'b1);
        chk("f_c1_ready", if_ready[1], 1'b0);
        nxt();
        chk("f_c2_ready", if_ready[1], 1'b1);
        chk("f_c2_data", if_data[1], 32'h3C01_0101);
        chk("f_c2_stall", stall_if[1], 1'b0);
        chk("f_c2_mem_ce", mem_ce[1], 1'b0);
        if_ce = 1'b0;
        nxt();
        chk("f_c3_ready", if_ready[1], 1'b0);

        // store then load, W=3
        do_reset();
        dm_ce = 1'b1; dm_we = 1'b1; dm_sel = 4'b0011; dm_addr = 32'h20; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 3; c++) begin
            nxt();
            chk($sformatf("st_c%0d_mem_ce", c), mem_ce[3], 1'b1);
            chk($sformatf("st_c%0d_mem_we", c), mem_we[3], 1'b1);
            chk($sformatf("st_c%0d_mem_sel", c), mem_sel[3], 4'b0011);
            chk($sformatf("st_c%0d_ready", c), dm_ready[3], 1'b0);
        end
        chk("st_wdata", mem_wdata[3], 32'hDEAD_BEEF);
        nxt();
        chk("st_c4_ready", dm_ready[3], 1'b1);
        chk("st_c4_mem_ce", mem_ce[3], 1'b0);
        dm_ce = 1'b0; dm_we = 1'b0; dm_sel = 4'hF;
        nxt();
        chk("st_c5_ready", dm_ready[3], 1'b0);
        dm_ce = 1'b1;
        for (int c = 1; c <= 3; c++) nxt();
        chk("ld_c3_mem_we", mem_we[3], 1'b0);
        nxt();
        chk("ld_c4_ready", dm_ready[3], 1'b1);
        chk("ld_c4_rdata", dm_rdata[3], 32'h1122_BEEF);
        dm_ce = 1'b0;

        // contention, W=2
        do_reset();
        if_ce = 1'b1; if_addr = 32'h10; dm_ce = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        nxt();
        chk("ct_c1_dm_grant", mem_addr[2], 32'h20);
        nxt();
        nxt();
        chk("ct_c3_dm_ready", dm_ready[2], 1'b1);
        chk("ct_c3_if_ready", if_ready[2], 1'b0);
        chk("ct_c3_stall_if", stall_if[2], 1'b1);
`ifndef MEM_ARB_ROUND_ROBIN_EN
        dm_ce = 1'b0;
`endif
        nxt();
        chk("ct_c4_mem_ce", mem_ce[2], 1'b0);
        nxt();
        chk("ct_c5_mem_ce", mem_ce[2], 1'b1);
        chk("ct_c5_if_grant", mem_addr[2], 32'h10);
        nxt();
        nxt();
        chk("ct_c7_if_ready", if_ready[2], 1'b1);
        chk("ct_c7_if_data", if_data[2], 32'h3C01_0101);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        nxt();
        nxt();
        chk("ct_c9_dm_again", mem_addr[2], 32'h20);
`endif
        if_ce = 1'b0; dm_ce = 1'b0;

        // fetch flushed mid-access, W=3
        do_reset();
        if_ce = 1'b1; if_addr = 32'h10;
        nxt();
        chk("fl_c1_mem_ce", mem_ce[3], 1'b1);
        if_ce = 1'b0;
        #1;
        chk("fl_c1_stall", stall_if[3], 1'b0);
        nxt();
        chk("fl_c2_mem_ce", mem_ce[3], 1'b1);
        nxt();
        chk("fl_c3_mem_ce", mem_ce[3], 1'b1);
        nxt();
        chk("fl_c4_ready", if_ready[3], 1'b1);
        chk("fl_c4_mem_ce", mem_ce[3], 1'b0);
        chk("fl_c4_stall", stall_if[3], 1'b0);

        // reset in the middle of a W=4 access
        do_reset();
        if_ce = 1'b1; if_addr = 32'h10;
        nxt();
        chk("rb_c1_mem_ce", mem_ce[4], 1'b1);
        nxt();
        chk("rb_c2_mem_ce", mem_ce[4], 1'b1);
        rst = 1'b1;
        nxt();
        chk("rb_c3_mem_ce", mem_ce[4], 1'b0);
        rst = 1'b0; if_ce = 1'b0;
        for (int c = 0; c < 4; c++) begin
            nxt();
            chk($sformatf("rb_quiet%0d_ready", c), if_ready[4], 1'b0);
            chk($sformatf("rb_quiet%0d_mem_ce", c), mem_ce[4], 1'b0);
        end
        chk("rb_if_data", if_data[4], 32'h0);
        if_ce = 1'b1;
        nxt();
        chk("rb_new_mem_ce", mem_ce[4], 1'b1);
        for (int c = 2; c <= 4; c++) nxt();
        chk("rb_new_c4_ready", if_ready[4], 1'b0);
        nxt();
        chk("rb_new_c5_ready", if_ready[4], 1'b1);
        chk("rb_new_data", if_data[4], 32'h3C01_0101);
        if_ce = 1'b0;
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
